// File: rtl/udma_stream_pkg.sv
// Purpose: shared datasize encodings, the packed output-word type and the size-to-bytes helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udma_stream_pkg;

    localparam int LANES   = 4;
    localparam int WORD_DW = 8 * LANES;

    localparam logic [1:0] DS_BYTE    = 2'b00;
    localparam logic [1:0] DS_HALF    = 2'b01;
    localparam logic [1:0] DS_WORD    = 2'b10;
    localparam logic [1:0] DS_ILLEGAL = 2'b11;

    // One packed output word: data, byte-valid mask and transfer-close flag.
    typedef struct packed {
        logic [WORD_DW-1:0] dat;
        logic [LANES-1:0]   be;
        logic               last;
    } pack_word_t;

    // Number of bytes carried by an element; the illegal encoding carries none.
    function automatic logic [2:0] ds_bytes(input logic [1:0] ds);
        case (ds)
            DS_BYTE: ds_bytes = 3'd1;
            DS_HALF: ds_bytes = 3'd2;
            DS_WORD: ds_bytes = 3'd4;
            default: ds_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/udma_stream_packer.sv
// Purpose: packs byte/half/word stream elements into little-endian 32-bit words with byte enables.
// Latency: a word completed by an accepted element is valid on the output the following cycle.
// Backpressure: in_ready_o drops when the element needs the output register and it is not free.
module udma_stream_packer
    import udma_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,   // only 32 (four byte lanes) is supported
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_clr_i,
    input  logic [TO_WIDTH-1:0]   cfg_timeout_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [1:0]            in_datasize_i,
    input  logic                  in_valid_i,
    input  logic                  in_sot_i,
    input  logic                  in_eot_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [3:0]            out_be_o,
    output logic                  out_valid_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic                  err_o
);

    // Accumulator; fill never rests at 4 because a full word moves out on the same edge.
    logic [WORD_DW-1:0]  acc_dat;
    logic [LANES-1:0]    acc_be;
    logic [2:0]          fill;
    logic [TO_WIDTH-1:0] to_cnt;

    pack_word_t          out_q;
    logic                out_vld;
    logic                err_q;

    logic [2:0]          elem_bytes;
    logic [3:0]          fill_sum;
    logic                elem_ill;
    logic                fits;
    logic                completes;
    logic                out_free;
    logic                in_rdy;
    logic                accept;
    logic                load_full;
    logic                ill_flush;
    logic                split_flush;
    logic                to_hit;
    logic                part_flush;
    logic [WORD_DW-1:0]  elem_mask;
    logic [LANES-1:0]    be_base;
    logic [WORD_DW-1:0]  elem_dat;
    logic [LANES-1:0]    elem_be;

    // Element lane mask and base byte-enable by datasize; bytes above the size are dropped.
    always_comb begin
        case (in_datasize_i)
            DS_BYTE: begin elem_mask = 32'h0000_00ff; be_base = 4'b0001; end
            DS_HALF: begin elem_mask = 32'h0000_ffff; be_base = 4'b0011; end
            DS_WORD: begin elem_mask = 32'hffff_ffff; be_base = 4'b1111; end
            default: begin elem_mask = 32'h0000_0000; be_base = 4'b0000; end
        endcase
    end

    // Fit / completion decision, handshake and flush causes for the current cycle.
    always_comb begin
        elem_bytes = ds_bytes(in_datasize_i);
        elem_ill   = (in_datasize_i == DS_ILLEGAL);
        fill_sum   = {1'b0, fill} + {1'b0, elem_bytes};
        fits       = !elem_ill && (fill_sum <= 4'd4) && !(in_sot_i && (fill != 3'd0));
        completes  = fits && ((fill_sum == 4'd4) || in_eot_i);
        out_free   = !out_vld || out_ready_i;
        elem_dat   = (in_data_i & elem_mask) << {fill[1:0], 3'b000};
        elem_be    = be_base << fill[1:0];

        // An illegal element only needs the output register when it closes a partial word.
        if (rst_i || cmd_clr_i)          in_rdy = 1'b0;
        else if (elem_ill)               in_rdy = (in_eot_i && (fill != 3'd0)) ? out_free : 1'b1;
        else if (!fits)                  in_rdy = 1'b0;
        else if (completes)              in_rdy = out_free;
        else                             in_rdy = 1'b1;

        accept      = in_valid_i && in_rdy;
        load_full   = accept && completes;
        ill_flush   = accept && elem_ill && in_eot_i && (fill != 3'd0);
        split_flush = in_valid_i && !rst_i && !cmd_clr_i && !elem_ill && !fits && out_free;
        to_hit      = (cfg_timeout_i != '0) && (to_cnt >= cfg_timeout_i) && (fill != 3'd0)
                      && !accept && out_free;
        part_flush  = ill_flush || split_flush || to_hit;
    end

    // Accumulator and output register: load a completed or flushed word, else keep packing.
    always_ff @(posedge clk_i) begin
        if (rst_i || cmd_clr_i) begin
            acc_dat <= '0;
            acc_be  <= '0;
            fill    <= 3'd0;
            out_q   <= '0;
            out_vld <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && elem_ill;
            if (load_full) begin
                out_q.dat  <= acc_dat | elem_dat;
                out_q.be   <= acc_be | elem_be;
                out_q.last <= in_eot_i;
                out_vld    <= 1'b1;
                acc_dat    <= '0;
                acc_be     <= '0;
                fill       <= 3'd0;
            end else if (part_flush) begin
                out_q.dat  <= acc_dat;
                out_q.be   <= acc_be;
                out_q.last <= ill_flush;
                out_vld    <= 1'b1;
                acc_dat    <= '0;
                acc_be     <= '0;
                fill       <= 3'd0;
            end else begin
                if (out_free) begin
                    out_vld <= 1'b0;
                end
                if (accept && fits) begin
                    acc_dat <= acc_dat | elem_dat;
                    acc_be  <= acc_be | elem_be;
                    fill    <= fill_sum[2:0];
                end
            end
        end
    end

    // Idle counter for a resting partial word; holds at the threshold until the flush can go out.
    always_ff @(posedge clk_i) begin
        if (rst_i || cmd_clr_i) begin
            to_cnt <= '0;
        end else if (accept || (fill == 3'd0) || load_full || part_flush) begin
            to_cnt <= '0;
        end else if ((to_cnt != '1) && !((cfg_timeout_i != '0) && (to_cnt >= cfg_timeout_i))) begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
        end
    end

    assign in_ready_o  = in_rdy;
    assign out_data_o  = out_q.dat;
    assign out_be_o    = out_q.be;
    assign out_last_o  = out_q.last;
    assign out_valid_o = out_vld;
    assign err_o       = err_q;

endmodule

// File: tb/tb_udma_stream_packer.sv
// Purpose: self-checking bench for udma_stream_packer: byte-queue reference model plus directed literal cases.
// Latency: model predicts outputs one cycle after the inputs it consumes.
// Backpressure: directed stalls and random out_ready_i toggling.
module tb_udma_stream_packer;
    import udma_stream_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_clr_i = 1'b0;
    logic [15:0] cfg_timeout_i = 16'd0;
    logic [31:0] in_data_i = 32'd0;
    logic [1:0]  in_datasize_i = 2'b00;
    logic        in_valid_i = 1'b0;
    logic        in_sot_i = 1'b0;
    logic        in_eot_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_be_o;
    logic        out_valid_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic        err_o;

    logic rnd_bp  = 1'b0;
    logic rnd_rdy = 1'b1;
    logic dir_rdy = 1'b1;
    assign out_ready_i = rnd_bp ? rnd_rdy : dir_rdy;

    int n_cmp = 0;
    int n_bad = 0;

    udma_stream_packer #(.DATA_WIDTH(32), .TO_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_clr_i(cmd_clr_i), .cfg_timeout_i(cfg_timeout_i),
        .in_data_i(in_data_i), .in_datasize_i(in_datasize_i), .in_valid_i(in_valid_i),
        .in_sot_i(in_sot_i), .in_eot_i(in_eot_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_be_o(out_be_o), .out_valid_o(out_valid_o),
        .out_last_o(out_last_o), .out_ready_i(out_ready_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: bytes waiting to be packed, plus the word on the output ----
    logic [7:0]  mq[$];
    int          mcnt = 0;
    bit          mv = 0, ml = 0, merr = 0, started = 0;
    logic [31:0] md = 0;
    logic [3:0]  mb = 0;
    logic [36:0] wlog[$];   // {last, be, data} of every word the DUT handed downstream

    task automatic emit(input bit last);
        md = 32'd0;
        mb = 4'd0;
        for (int i = 0; i < mq.size(); i++) begin
            md[i*8 +: 8] = mq[i];
            mb[i] = 1'b1;
        end
        ml = last;
        mv = 1;
        mq.delete();
    endtask

    task automatic model_step();
        int n, fill;
        bit ill, fits, comp, free, rdy, acc, flushed;
        logic [31:0] d;
        if (rst_i) begin
            chk("mdl_ready_in_reset", in_ready_o, 0);
            mq.delete(); mcnt = 0; mv = 0; ml = 0; md = 0; mb = 0; merr = 0; started = 1;
            return;
        end
        if (!started) return;
        fill = mq.size();
        free = !mv || out_ready_i;
        case (in_datasize_i)
            2'b00: n = 1;
            2'b01: n = 2;
            2'b10: n = 4;
            default: n = 0;
        endcase
        ill  = (in_datasize_i == 2'b11);
        fits = !ill && (fill + n <= 4) && !(in_sot_i && fill > 0);
        comp = fits && ((fill + n == 4) || in_eot_i);
        if (cmd_clr_i)             rdy = 0;
        else if (ill)              rdy = (in_eot_i && fill > 0) ? free : 1;
        else if (!fits)            rdy = 0;
        else if (comp)             rdy = free;
        else                       rdy = 1;
        if (in_valid_i) chk("mdl_in_ready", in_ready_o, rdy);
        if (cmd_clr_i) begin
            mq.delete(); mcnt = 0; mv = 0; merr = 0;
            return;
        end
        acc  = in_valid_i && rdy;
        merr = acc && ill;
        if (free) mv = 0;
        flushed = 0;
        d = in_data_i;
        if (acc && !ill) begin
            for (int i = 0; i < n; i++) mq.push_back(d[i*8 +: 8]);
            if (comp) begin emit(in_eot_i); flushed = 1; end
        end else if (acc && ill && in_eot_i && fill > 0) begin
            emit(1); flushed = 1;
        end else if (in_valid_i && !ill && !fits && free) begin
            emit(0); flushed = 1;
        end else if (!acc && fill > 0 && cfg_timeout_i != 0 && mcnt >= cfg_timeout_i && free) begin
            emit(0); flushed = 1;
        end
        if (acc || flushed || fill == 0) mcnt = 0;
        else mcnt = mcnt + 1;
    endtask

    // Single compare process: outputs against the model every cycle, then advance the model.
    always @(negedge clk_i) begin
        if (started) begin
            chk("mdl_out_valid", out_valid_o, mv);
            if (mv) begin
                chk("mdl_out_data", out_data_o, md);
                chk("mdl_out_be", out_be_o, mb);
                chk("mdl_out_last", out_last_o, ml);
            end
            chk("mdl_err", err_o, merr);
            if (out_valid_o && out_ready_i) wlog.push_back({out_last_o, out_be_o, out_data_o});
        end
        model_step();
    end

    always begin
        @(posedge clk_i); #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run, expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (entered and left just after a rising edge) ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] s, input logic so, input logic eo,
                        output int stalls);
        bit got = 0;
        in_data_i = d; in_datasize_i = s; in_sot_i = so; in_eot_i = eo; in_valid_i = 1'b1;
        stalls = 0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk_i);
            if (in_ready_o) begin got = 1; break; end
            stalls++;
            step();
        end
        if (!got) chk("send_timeout", 0, 1);
        step();
        in_valid_i = 1'b0; in_sot_i = 1'b0; in_eot_i = 1'b0;
    endtask

    task automatic expect_log(input string nm, input int idx, input logic [36:0] exp);
        if (wlog.size() > idx) chk(nm, wlog[idx], exp);
        else chk({nm, "_missing"}, wlog.size(), idx + 1);
    endtask

    int st;
    int waited;
    logic [31:0] rd;
    logic [1:0]  rs;

    initial begin
        repeat (3) step();
        @(negedge clk_i);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_be", out_be_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        step();
        rst_i = 1'b0;
        step();

        // Four bytes into one word, closing the transfer.
        send(32'hFFFFFF11, DS_BYTE, 1, 0, st);
        send(32'h00000022, DS_BYTE, 0, 0, st);
        send(32'hABCDEF33, DS_BYTE, 0, 0, st);
        send(32'h00000044, DS_BYTE, 0, 1, st);
        @(negedge clk_i);
        chk("w4_valid", out_valid_o, 1);
        chk("w4_data", out_data_o, 32'h44332211);
        chk("w4_be", out_be_o, 4'b1111);
        chk("w4_last", out_last_o, 1);
        step();

        // Half with eot.
        send(32'h1234BEEF, DS_HALF, 1, 1, st);
        @(negedge clk_i);
        chk("half_data", out_data_o, 32'h0000BEEF);
        chk("half_be", out_be_o, 4'b0011);
        chk("half_last", out_last_o, 1);
        step();
        step();

        // Byte then word: partial flushed, one stall.
        wlog.delete();
        send(32'h000000AA, DS_BYTE, 1, 0, st);
        send(32'hDEADBEEF, DS_WORD, 0, 0, st);
        chk("split_stalls", st, 1);
        repeat (3) step();
        expect_log("split_w0", 0, {1'b0, 4'b0001, 32'h000000AA});
        expect_log("split_w1", 1, {1'b0, 4'b1111, 32'hDEADBEEF});

        // Illegal datasize with eot while two bytes are packed.
        send(32'h00001234, DS_HALF, 1, 0, st);
        send(32'hFFFFFFFF, DS_ILLEGAL, 0, 1, st);
        @(negedge clk_i);
        chk("ill_err", err_o, 1);
        chk("ill_valid", out_valid_o, 1);
        chk("ill_data", out_data_o, 32'h00001234);
        chk("ill_be", out_be_o, 4'b0011);
        chk("ill_last", out_last_o, 1);
        step();
        @(negedge clk_i);
        chk("ill_err_pulse", err_o, 0);
        step();

        // Output held for five cycles while the next word's completing byte waits.
        wlog.delete();
        dir_rdy = 1'b0;
        send(32'h000000A1, DS_BYTE, 1, 0, st);
        send(32'h000000A2, DS_BYTE, 0, 0, st);
        send(32'h000000A3, DS_BYTE, 0, 0, st);
        send(32'h000000A4, DS_BYTE, 0, 1, st);
        send(32'h000000B1, DS_BYTE, 1, 0, st);
        send(32'h000000B2, DS_BYTE, 0, 0, st);
        send(32'h000000B3, DS_BYTE, 0, 0, st);
        in_data_i = 32'h000000B4; in_datasize_i = DS_BYTE; in_eot_i = 1'b1; in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("hold_in_ready", in_ready_o, 0);
            chk("hold_valid", out_valid_o, 1);
            chk("hold_data", out_data_o, 32'hA4A3A2A1);
            step();
        end
        dir_rdy = 1'b1;
        @(negedge clk_i);
        chk("release_in_ready", in_ready_o, 1);
        step();
        in_valid_i = 1'b0; in_eot_i = 1'b0;
        repeat (3) step();
        expect_log("hold_w0", 0, {1'b1, 4'b1111, 32'hA4A3A2A1});
        expect_log("hold_w1", 1, {1'b1, 4'b1111, 32'hB4B3B2B1});
        chk("hold_count", wlog.size(), 2);

        // Clear mid-transfer with a pending word and a partial byte.
        dir_rdy = 1'b0;
        send(32'h000000C1, DS_BYTE, 1, 0, st);
        send(32'h000000C2, DS_BYTE, 0, 0, st);
        send(32'h000000C3, DS_BYTE, 0, 0, st);
        send(32'h000000C4, DS_BYTE, 0, 1, st);
        send(32'h00000077, DS_BYTE, 1, 0, st);
        cmd_clr_i = 1'b1;
        in_data_i = 32'h00000088; in_datasize_i = DS_BYTE; in_valid_i = 1'b1;
        @(negedge clk_i);
        chk("clr_in_ready", in_ready_o, 0);
        step();
        cmd_clr_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("clr_out_valid", out_valid_o, 0);
        step();
        dir_rdy = 1'b1;
        send(32'h00000066, DS_BYTE, 1, 1, st);
        @(negedge clk_i);
        chk("clr_fill_data", out_data_o, 32'h00000066);
        chk("clr_fill_be", out_be_o, 4'b0001);
        step();

        // Timeout flush of a lone byte.
        cfg_timeout_i = 16'd3;
        send(32'h0000005A, DS_BYTE, 1, 0, st);
        waited = 0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk_i);
            if (out_valid_o) begin waited = w; break; end
        end
        chk("to_wait", waited, 5);
        chk("to_data", out_data_o, 32'h0000005A);
        chk("to_be", out_be_o, 4'b0001);
        chk("to_last", out_last_o, 0);
        step();

        // Random traffic with random downstream backpressure.
        rnd_bp = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cmd_clr_i = 1'b1;
                case ($urandom_range(0, 5))
                    0: cfg_timeout_i = 16'd0;
                    1: cfg_timeout_i = 16'd1;
                    2: cfg_timeout_i = 16'd2;
                    3: cfg_timeout_i = 16'd3;
                    4: cfg_timeout_i = 16'd5;
                    default: cfg_timeout_i = 16'd8;
                endcase
                step();
                cmd_clr_i = 1'b0;
            end else if (r < 20) begin
                repeat ($urandom_range(1, 6)) step();
            end
            rd = $urandom;
            rs = ($urandom_range(0, 19) == 0) ? DS_ILLEGAL : 2'($urandom_range(0, 2));
            send(rd, rs, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), st);
        end
        rnd_bp = 1'b0;
        dir_rdy = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
